alu16_seq: RTL and testbench
============================

ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-004 req_valid  in  1  operation request.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 opa, opb  in  16  operands, active-high data.
REQ-007 sel  in  4  function select, same encoding as the 4-bit ALU slice.
REQ-008 mode  in  1  1 = logic, 0 = arithmetic.
REQ-009 cin_n  in  1  active-low carry in.
REQ-010 flush  in  1  synchronous abort.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  consumer accepts the result.
REQ-013 result  out  16  function output.
REQ-014 cout_n  out  1  active-low carry out of the most significant nibble.
REQ-015 aeb  out  1  AND of all 16 result bits.
REQ-016 busy  out  1  asserted when state is not IDLE.

Function
REQ-017 The block SHALL sequence a single combinational 4-bit ALU slice over four cycles, one nibble per cycle, LSB nibble first, to compute a 16-bit result.
REQ-018 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-019 req_ready SHALL be 1 in IDLE, and 1 in DONE only while res_ready=1; it SHALL be 0 in RUN.
REQ-020 On accept (req_valid & req_ready), the block SHALL latch opa, opb, sel, mode and cin_n, load the nibble index with 0, load the carry register with cin_n, and enter RUN.
REQ-021 In each RUN cycle, the block SHALL feed nibble k of the operands and the carry register to the slice, write slice F into result[4k+3:4k], load the carry register with the slice carry-out, and AND the slice equality output into the aeb accumulator.
REQ-022 The nibble index SHALL increment 0 to 3; on index 3 the FSM SHALL enter DONE and the index SHALL wrap to 0.
REQ-023 Latency: with accept on edge 0, RUN occupies cycles 1-4 and res_valid=1 from cycle 5.
REQ-024 In DONE, res_valid=1 and result, cout_n and aeb SHALL hold stable until res_ready=1.
REQ-025 In DONE with res_ready=1 and req_valid=0, the FSM SHALL go to IDLE.
REQ-026 In DONE with res_ready=1 and req_valid=1, the block SHALL accept the new request in the same cycle and go directly to RUN, with no bubble.
REQ-027 When mode=1, the carry chain SHALL still propagate, but result SHALL depend only on sel and the operands.
REQ-028 cout_n SHALL equal the slice carry-out of nibble 3.
REQ-029 In RUN, result SHALL show partially written nibbles; consumers SHALL sample result only when res_valid=1.
REQ-030 flush=1 in any state SHALL force IDLE on the next edge, with res_valid=0; result SHALL keep its last value.
REQ-031 flush SHALL take priority over an accept in the same cycle.
REQ-032 Input operand changes after accept SHALL have no effect on the operation in progress.

Reset
REQ-033 While rst_n=0, the block SHALL immediately set: state IDLE, res_valid 0, busy 0, result 16'h0000, cout_n 1, aeb 0, nibble index 0, carry register 1.
REQ-034 A reset asserted mid-operation SHALL abandon that operation; after rst_n deasserts, the first edge with req_valid=1 SHALL be accepted.

Structure
REQ-035 Package alu16_pkg SHALL hold the state enum, NIBBLES=4, and the select constants SEL_ADD=4'b1001, SEL_SUB=4'b0110 and SEL_AND=4'b1011.
REQ-036 The block SHALL instantiate exactly one sub-module, alu4_slice (combinational: S, A, B, M, CNb in; F, CN4b, AEB out), plus the FSM and registers.

Verification
REQ-037 Add: sel=1001, mode=0, cin_n=1, opa=1234, opb=0FCD -> result=2201, cout_n=1, res_valid on cycle 5.
REQ-038 Carry wrap: sel=1001, mode=0, cin_n=1, opa=FFFF, opb=0001 -> result=0000, cout_n=0.
REQ-039 Subtract: sel=0110, mode=0, cin_n=0, opa=5000, opb=0001 -> result=4FFF, cout_n=0.
REQ-040 Compare: sel=0110, mode=0, cin_n=1, opa=opb=ABCD -> result=FFFF, aeb=1; with opb=ABCC -> aeb=0.
REQ-041 Logic and back-to-back: sel=1011, mode=1, opa=F0F0, opb=3C3C -> result=3030; hold res_ready=0 for 3 cycles -> outputs stable; then res_ready=1 together with req_valid=1 -> second request accepted in the same cycle.
REQ-042 Abort: flush=1 in RUN cycle 2 -> IDLE next cycle, res_valid stays 0; rst_n pulsed low mid-RUN -> all outputs at reset values at once.

Source files
------------

// File: rtl/alu16_pkg.sv
// alu16_pkg -- shared definitions for the nibble-serial 16-bit ALU.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   NIBBLES   : number of 4-bit slices per 16-bit word
//   NIB_W     : width of the nibble index
//   SEL_*     : commonly used function-select codes for the 4-bit slice
package alu16_pkg;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = $clog2(NIBBLES);

    localparam logic [3:0] SEL_ADD = 4'b1001;   // A plus B (mode 0)
    localparam logic [3:0] SEL_SUB = 4'b0110;   // A minus B minus 1, +1 with cin_n=0
    localparam logic [3:0] SEL_AND = 4'b1011;   // A and B (mode 1)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu4_slice.sv
// alu4_slice -- combinational 4-bit ALU slice, active-high data, active-low carries.
//   S    in  4 : function select
//   A, B in  4 : operands
//   M    in  1 : 1 = logic, 0 = arithmetic
//   CNb  in  1 : active-low carry in
//   F    out 4 : function output
//   CN4b out 1 : active-low carry out
//   AEB  out 1 : AND of all F bits
module alu4_slice (
    input  logic [3:0] S,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       M,
    input  logic       CNb,
    output logic [3:0] F,
    output logic       CN4b,
    output logic       AEB
);

    logic [3:0] or_term;
    logic [3:0] and_term;
    logic [4:0] sum;

    always_comb begin
        // Every arithmetic function is or_term plus and_term plus carry; and_term
        // bits are a subset of or_term bits, just like the classic slice.
        or_term  = A | (B & {4{S[0]}}) | (~B & {4{S[1]}});
        and_term = (A & ~B & {4{S[2]}}) | (A & B & {4{S[3]}});
        sum      = {1'b0, or_term} + {1'b0, and_term} + {4'b0000, ~CNb};

        // Carry chain runs regardless of mode; logic mode just ignores the
        // internal carries, which reduces F to the inverted half-sum.
        CN4b = ~sum[4];
        if (M) begin
            F = ~(or_term ^ and_term);
        end else begin
            F = sum[3:0];
        end
        AEB = &F;
    end

endmodule

// File: rtl/alu16_seq.sv
// alu16_seq -- 16-bit ALU built from one 4-bit slice, sequenced one nibble per
// cycle (LSB first) with a valid/ready request and result handshake.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake (opa, opb, sel, mode, cin_n)
//   flush               : synchronous abort back to IDLE
//   res_valid/res_ready : result handshake (result, cout_n, aeb)
//   busy                : state is not IDLE
//
//   state | meaning
//   IDLE  | waiting for a request
//   RUN   | one nibble processed per cycle, index 0..3
//   DONE  | result valid, held until res_ready
module alu16_seq
    import alu16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [3:0]  sel,
    input  logic        mode,
    input  logic        cin_n,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        cout_n,
    output logic        aeb,
    output logic        busy
);

    state_t             state_q,     state_d;
    logic [NIB_W-1:0]   nib_q,       nib_d;
    logic               carry_q,     carry_d;     // active-low, like the slice
    logic               aeb_q,       aeb_d;
    logic [15:0]        result_q,    result_d;
    logic [15:0]        opa_q,       opa_d;
    logic [15:0]        opb_q,       opb_d;
    logic [3:0]         sel_q,       sel_d;
    logic               mode_q,      mode_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q,      busy_d;

    logic [3:0]         slice_f;
    logic               slice_cn4b;
    logic               slice_aeb;
    logic               accept;

    alu4_slice u_slice (
        .S    (sel_q),
        .A    (opa_q[{nib_q, 2'b00} +: 4]),
        .B    (opb_q[{nib_q, 2'b00} +: 4]),
        .M    (mode_q),
        .CNb  (carry_q),
        .F    (slice_f),
        .CN4b (slice_cn4b),
        .AEB  (slice_aeb)
    );

    assign req_ready = (state_q == IDLE) || ((state_q == DONE) && res_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        nib_d    = nib_q;
        carry_d  = carry_q;
        aeb_d    = aeb_q;
        result_d = result_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sel_d    = sel_q;
        mode_d   = mode_q;

        if (flush) begin
            // Abort wins over any accept; result is intentionally left as-is.
            state_d = IDLE;
            nib_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    result_d[{nib_q, 2'b00} +: 4] = slice_f;
                    carry_d = slice_cn4b;
                    aeb_d   = aeb_q & slice_aeb;
                    nib_d   = nib_q + 1'b1;
                    if (nib_q == NIB_W'(NIBBLES - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (res_ready && !req_valid) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase

            // Accept is only possible from IDLE or DONE, so it never collides
            // with the RUN updates above. The carry register doubles as the
            // latched cin_n.
            if (accept) begin
                opa_d   = opa;
                opb_d   = opb;
                sel_d   = sel;
                mode_d  = mode;
                carry_d = cin_n;
                aeb_d   = 1'b1;
                nib_d   = '0;
                state_d = RUN;
            end
        end

        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nib_q       <= '0;
            carry_q     <= 1'b1;
            aeb_q       <= 1'b0;
            result_q    <= 16'h0000;
            opa_q       <= 16'h0000;
            opb_q       <= 16'h0000;
            sel_q       <= 4'h0;
            mode_q      <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            carry_q     <= carry_d;
            aeb_q       <= aeb_d;
            result_q    <= result_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    // After nibble 3 the carry register holds that nibble's carry-out.
    assign cout_n    = carry_q;
    assign aeb       = aeb_q;

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;
    import alu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [3:0]  sel;
    logic        mode;
    logic        cin_n;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic        cout_n;
    logic        aeb;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opa       (opa),
        .opb       (opb),
        .sel       (sel),
        .mode      (mode),
        .cin_n     (cin_n),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .cout_n    (cout_n),
        .aeb       (aeb),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  sel;
        logic        mode;
        logic        cin_n;
        logic [15:0] opa;
        logic [15:0] opb;
        logic [15:0] exp_result;
        logic        exp_cout_n;
        logic        exp_aeb;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        sel       = v.sel;
        mode      = v.mode;
        cin_n     = v.cin_n;
        opa       = v.opa;
        opb       = v.opb;
        req_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        req_valid = 1'b0;
        opa       = ~opa;
        opb       = 16'($urandom);
        sel       = ~sel;
        mode      = ~mode;
        cin_n     = ~cin_n;
    endtask

    task automatic drain();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_res_valid", 16'(res_valid), 16'h0);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_req(v);
        #1;
        check($sformatf("v%0d_req_ready", idx), 16'(req_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) check($sformatf("v%0d_lat%0d", idx, k), 16'(res_valid), 16'h0);
            else       check($sformatf("v%0d_res_valid", idx), 16'(res_valid), 16'h1);
        end
        check($sformatf("v%0d_result", idx), result, v.exp_result);
        check($sformatf("v%0d_cout_n", idx), 16'(cout_n), 16'(v.exp_cout_n));
        check($sformatf("v%0d_aeb", idx), 16'(aeb), 16'(v.exp_aeb));
        drain();
    endtask

    initial begin
        vec_t va;
        vec_t vb;

        //           sel      mode  cin_n  opa       opb       result    cout_n aeb
        vecs[0] = '{SEL_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FCD, 16'h2201, 1'b1, 1'b0};
        vecs[1] = '{SEL_ADD, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{SEL_SUB, 1'b0, 1'b0, 16'h5000, 16'h0001, 16'h4FFF, 1'b0, 1'b0};
        vecs[3] = '{SEL_SUB, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 16'hFFFF, 1'b1, 1'b1};
        vecs[4] = '{SEL_SUB, 1'b0, 1'b1, 16'hABCD, 16'hABCC, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{SEL_AND, 1'b1, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        vecs[6] = '{4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0};
        vecs[7] = '{4'b1100, 1'b1, 1'b1, 16'h8001, 16'h1234, 16'hFFFF, 1'b0, 1'b1};
        vecs[8] = '{4'b1111, 1'b0, 1'b1, 16'h0000, 16'h5555, 16'hFFFF, 1'b1, 1'b1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        flush     = 1'b0;
        opa       = 16'h0;
        opb       = 16'h0;
        sel       = 4'h0;
        mode      = 1'b0;
        cin_n     = 1'b1;

        #12;
        check("rst_result", result, 16'h0000);
        check("rst_cout_n", 16'(cout_n), 16'h1);
        check("rst_aeb", 16'(aeb), 16'h0);
        check("rst_res_valid", 16'(res_valid), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_req_ready", 16'(req_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Stall in DONE, then back-to-back accept with no bubble.
        va = vecs[5];
        vb = vecs[0];
        @(negedge clk);
        drive_req(va);
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        repeat (4) @(posedge clk);
        #1;
        check("hold_res_valid", 16'(res_valid), 16'h1);
        check("hold_result", result, 16'h3030);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_result", k), result, 16'h3030);
            check($sformatf("hold%0d_res_valid", k), 16'(res_valid), 16'h1);
            check($sformatf("hold%0d_cout_n", k), 16'(cout_n), 16'h0);
        end
        @(negedge clk);
        drive_req(vb);
        res_ready = 1'b1;
        #1;
        check("b2b_req_ready", 16'(req_ready), 16'h1);
        @(posedge clk);
        #1;
        check("b2b_busy", 16'(busy), 16'h1);
        check("b2b_res_valid", 16'(res_valid), 16'h0);
        @(negedge clk);
        scramble_inputs();
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_lat3", 16'(res_valid), 16'h0);
        @(posedge clk);
        #1;
        check("b2b_res_valid_done", 16'(res_valid), 16'h1);
        check("b2b_result", result, 16'h2201);
        drain();

        // Flush in RUN cycle 2: nibble 0 (3+4=7) already written, rest kept.
        va = '{SEL_ADD, 1'b0, 1'b1, 16'h0003, 16'h0004, 16'h0007, 1'b1, 1'b0};
        @(negedge clk);
        drive_req(va);
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 16'(busy), 16'h0);
        check("flush_res_valid", 16'(res_valid), 16'h0);
        check("flush_result", result, 16'h2207);
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("flush_stays_idle", 16'(res_valid), 16'h0);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        drive_req(vecs[0]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_vs_accept_busy", 16'(busy), 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;

        // Reset mid-RUN.
        @(negedge clk);
        drive_req(vecs[5]);
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_result", result, 16'h0000);
        check("midrst_cout_n", 16'(cout_n), 16'h1);
        check("midrst_aeb", 16'(aeb), 16'h0);
        check("midrst_res_valid", 16'(res_valid), 16'h0);
        check("midrst_busy", 16'(busy), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(vecs[0]);
        @(posedge clk);
        #1;
        check("postrst_busy", 16'(busy), 16'h1);
        @(negedge clk);
        scramble_inputs();
        repeat (4) @(posedge clk);
        #1;
        check("postrst_res_valid", 16'(res_valid), 16'h1);
        check("postrst_result", result, 16'h2201);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
